// File: rtl/operand_bank_proc_pkg.sv
// Shared encodings for the operand bank reduction engine.
// Op select values and FSM state constants.
package operand_bank_proc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_XOR = 2'd1;
  localparam logic [1:0] OP_MAX = 2'd2;
  localparam logic [1:0] OP_MIN = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/operand_bank_proc_reduce_alu.sv
// Combinational two-operand combine step for the reduction.
// Carry is only meaningful for ADD and is forced low otherwise.
import operand_bank_proc_pkg::*;

module reduce_alu #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y,
  output logic         carry
);

  logic [W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    unique case (op)
      OP_ADD: begin
        y     = sum[W-1:0];
        carry = sum[W];
      end
      OP_XOR: y = a ^ b;
      OP_MAX: y = (a > b) ? a : b;
      OP_MIN: y = (a < b) ? a : b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/operand_bank_proc.sv
// N-channel operand bank with edge-detected loads and a
// sequential ADD/XOR/MAX/MIN reduction, one operand per cycle.
import operand_bank_proc_pkg::*;

module operand_bank_proc #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_in,
  input  logic [N-1:0] load_stb,
  input  logic         start,
  input  logic [1:0]   op,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic         load_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  opr_q [N];
  logic [N-1:0]  stb_q;
  logic [0:0]    st_q;
  logic [1:0]    op_q;
  logic [W-1:0]  acc_q;
  logic          cy_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  result_q;
  logic          ovf_q;
  logic          done_q;
  logic          valid_q;
  logic          lerr_q;

  logic [N-1:0]  rise;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_y;
  logic          alu_c;
  logic          cy_d;
  logic          last;

  assign rise = load_stb & ~stb_q;
  assign cy_d = cy_q | alu_c;
  assign last = (idx_q == IW'(N - 1));

  generate
    if (N == 1) begin : g_one
      assign alu_b = opr_q[0];
    end else begin : g_many
      assign alu_b = opr_q[idx_q];
    end
  endgenerate

  reduce_alu #(.W(W)) u_alu (
    .a     (acc_q),
    .b     (alu_b),
    .op    (op_q),
    .y     (alu_y),
    .carry (alu_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) opr_q[i] <= '0;
      stb_q    <= '0;
      st_q     <= ST_IDLE;
      op_q     <= OP_ADD;
      acc_q    <= '0;
      cy_q     <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      stb_q  <= load_stb;
      done_q <= 1'b0;
      lerr_q <= 1'b0;
      if (st_q == ST_IDLE) begin
        for (int i = 0; i < N; i++)
          if (rise[i]) opr_q[i] <= data_in;
        if (start) begin
          op_q    <= op;
          acc_q   <= opr_q[0];
          cy_q    <= 1'b0;
          idx_q   <= IW'(1);
          valid_q <= 1'b0;
          // A single operand is already the reduction.
          if (N == 1) begin
            result_q <= opr_q[0];
            ovf_q    <= 1'b0;
            valid_q  <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            st_q <= ST_RUN;
          end
        end
      end else begin
        lerr_q <= |rise;
        acc_q  <= alu_y;
        cy_q   <= cy_d;
        idx_q  <= idx_q + 1'b1;
        if (last) begin
          result_q <= alu_y;
          ovf_q    <= cy_d;
          valid_q  <= 1'b1;
          done_q   <= 1'b1;
          st_q     <= ST_IDLE;
        end
      end
    end
  end

  assign result   = result_q;
  assign ovf      = ovf_q;
  assign busy     = (st_q == ST_RUN);
  assign done     = done_q;
  assign valid    = valid_q;
  assign load_err = lerr_q;

endmodule

// File: tb/tb_operand_bank_proc.sv
// Bench for operand_bank_proc: directed scenarios plus random
// traffic checked every cycle against a behavioural model.
module tb_operand_bank_proc;

  localparam int W = 4;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] data_in;
  logic [N-1:0] load_stb;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] result;
  logic         ovf, busy, done, valid, load_err;

  logic         b_rst;
  logic [7:0]   b_data;
  logic [0:0]   b_stb;
  logic         b_start;
  logic [1:0]   b_op;
  logic [7:0]   b_result;
  logic         b_ovf, b_busy, b_done, b_valid, b_lerr;

  operand_bank_proc #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_stb(load_stb),
    .start(start), .op(op), .result(result), .ovf(ovf),
    .busy(busy), .done(done), .valid(valid), .load_err(load_err)
  );

  operand_bank_proc #(.W(8), .N(1)) dut1 (
    .clk(clk), .rst(b_rst), .data_in(b_data), .load_stb(b_stb),
    .start(b_start), .op(b_op), .result(b_result), .ovf(b_ovf),
    .busy(b_busy), .done(b_done), .valid(b_valid), .load_err(b_lerr)
  );

  int n_cmp = 0;
  int n_fail = 0;

  int       m_reg [N];
  int       snap [N];
  int       old0;
  logic [N-1:0] m_prev, m_rise;
  bit       m_run;
  int       m_cnt;
  int       m_pres;
  bit       m_povf;
  int       e_res;
  bit       e_ovf, e_valid, e_done, e_busy, e_lerr;
  bit       m_live = 1'b0;

  function automatic void reduce(input int r[N], input int o,
                                 output int res, output bit ov);
    int acc;
    acc = r[0];
    ov = 1'b0;
    for (int i = 1; i < N; i++) begin
      case (o)
        0: acc = acc + r[i];
        1: acc = acc ^ r[i];
        2: acc = (r[i] > acc) ? r[i] : acc;
        default: acc = (r[i] < acc) ? r[i] : acc;
      endcase
    end
    if (o == 0) begin
      ov  = (acc >= (1 << W));
      acc = acc % (1 << W);
    end
    res = acc;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_reg[i] = 0;
      m_prev = '0; m_run = 1'b0; m_cnt = 0;
      e_res = 0; e_ovf = 0; e_valid = 0;
      e_done = 0; e_busy = 0; e_lerr = 0;
    end else begin
      m_rise = load_stb & ~m_prev;
      m_prev = load_stb;
      e_done = 1'b0;
      e_lerr = 1'b0;
      if (m_run) begin
        e_lerr = (m_rise != '0);
        m_cnt--;
        if (m_cnt == 0) begin
          m_run = 1'b0;
          e_res = m_pres; e_ovf = m_povf;
          e_valid = 1'b1; e_done = 1'b1;
        end
      end else begin
        old0 = m_reg[0];
        for (int i = 0; i < N; i++)
          if (m_rise[i]) m_reg[i] = int'(data_in);
        if (start) begin
          snap = m_reg;
          snap[0] = old0;
          reduce(snap, int'(op), m_pres, m_povf);
          e_valid = 1'b0;
          m_run = 1'b1;
          m_cnt = N - 1;
        end
      end
      e_busy = m_run;
    end
    m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      n_cmp++;
      if (result !== W'(e_res) || ovf !== e_ovf || busy !== e_busy ||
          done !== e_done || valid !== e_valid || load_err !== e_lerr) begin
        n_fail++;
        $display("FAIL model t=%0t got res=%0d ovf=%b busy=%b done=%b valid=%b lerr=%b exp res=%0d ovf=%b busy=%b done=%b valid=%b lerr=%b",
                 $time, result, ovf, busy, done, valid, load_err,
                 e_res, e_ovf, e_busy, e_done, e_valid, e_lerr);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic wait_done(input string nm, inout int n);
    while (!done && n < 12) begin
      cyc();
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout got=no_done exp=done", nm);
    end
  endtask

  task automatic load(input int ch, input int v);
    data_in = W'(v);
    load_stb = N'(1 << ch);
    cyc();
    load_stb = '0;
    cyc();
  endtask

  task automatic run_op(input string nm, input int o, input int er, input int eo);
    int n;
    start = 1'b1;
    op = 2'(o);
    cyc();
    start = 1'b0;
    n = 1;
    wait_done(nm, n);
    chk({nm, "_lat"}, n, 4);
    chk({nm, "_res"}, result, er);
    chk({nm, "_ovf"}, ovf, eo);
    chk({nm, "_valid"}, valid, 1);
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; data_in = '0; load_stb = '0; start = 1'b0; op = 2'd0;
    b_rst = 1'b1; b_data = '0; b_stb = '0; b_start = 1'b0; b_op = 2'd0;
    cyc();
    cyc();
    chk("rst_result", result, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    b_rst = 1'b0;

    load(0, 3); load(1, 5); load(2, 7); load(3, 9);
    run_op("add", 0, 8, 1);
    run_op("xor", 1, 8, 0);
    run_op("max", 2, 9, 0);
    run_op("min", 3, 3, 0);

    for (int v = 1; v <= 5; v++) begin
      data_in = W'(v);
      load_stb = 4'b0100;
      cyc();
    end
    load_stb = '0;
    cyc();
    run_op("held_min", 3, 1, 0);

    start = 1'b1; op = 2'd0;
    cyc();
    start = 1'b0;
    data_in = 4'd15; load_stb = 4'b0010; start = 1'b1; op = 2'd2;
    cyc();
    chk("lerr_pulse", load_err, 1);
    load_stb = '0; start = 1'b0; op = 2'd0;
    cyc();
    chk("lerr_clear", load_err, 0);
    n = 3;
    wait_done("frozen_add", n);
    chk("frozen_lat", n, 4);
    chk("frozen_res", result, 2);
    chk("frozen_ovf", ovf, 1);
    run_op("frozen_max", 2, 9, 0);

    start = 1'b1; op = 2'd0;
    cyc();
    start = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    run_op("post_rst_add", 0, 0, 0);

    b_data = 8'd200; b_stb = 1'b1;
    cyc();
    b_stb = 1'b0;
    cyc();
    b_start = 1'b1; b_op = 2'd0;
    cyc();
    b_start = 1'b0;
    chk("n1_done", b_done, 1);
    chk("n1_res", b_result, 200);
    chk("n1_ovf", b_ovf, 0);
    chk("n1_valid", b_valid, 1);
    chk("n1_busy", b_busy, 0);
    cyc();
    chk("n1_done_clr", b_done, 0);

    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      load_stb = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      data_in = W'($urandom);
      start = ($urandom_range(0, 4) == 0);
      op = 2'($urandom);
      cyc();
    end
    rst = 1'b0; load_stb = '0; start = 1'b0;
    for (int i = 0; i < 6; i++) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_bank_proc.md
OPERAND_BANK_PROC -- requirements
Module: operand_bank_proc

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning operand/result width in bits (W >= 2).
REQ-002 The block SHALL have parameter N, default 4, meaning the number of operand channels (1 <= N <= 16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port data_in, input, W bits: operand value presented for loading.
REQ-006 The block SHALL have port load_stb, input, N bits: per-channel load strobe, bit i selects operand register i.
REQ-007 The block SHALL have port start, input, 1 bit: request to run one reduction over all N operands.
REQ-008 The block SHALL have port op, input, 2 bits: reduction select; 0 ADD, 1 XOR, 2 MAX, 3 MIN (unsigned).
REQ-009 The block SHALL have port result, output, W bits: registered reduction result.
REQ-010 The block SHALL have port ovf, output, 1 bit: ADD carry-out occurred during the last reduction.
REQ-011 The block SHALL have port busy, output, 1 bit: reduction in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new result.
REQ-013 The block SHALL have port valid, output, 1 bit: result holds a completed reduction.
REQ-014 The block SHALL have port load_err, output, 1 bit: one-cycle pulse marking a load strobe rejected while busy.

Function
REQ-015 Loads SHALL be rising-edge detected per channel: register i loads data_in at the edge where load_stb[i]=1 and its registered previous value was 0; a held strobe loads once.
REQ-016 Several channels with simultaneous rising strobes SHALL all load the same data_in value in that cycle.
REQ-017 The FSM SHALL have states IDLE and RUN; start is sampled only in IDLE and is ignored in RUN.
REQ-018 At the start edge k the block SHALL latch op, set acc=reg[0], clear the overflow flag, and set idx=1, then:
- go to RUN when N>1;
- finish immediately when N=1.
REQ-019 In RUN, each edge SHALL apply acc=f(acc, reg[idx]) and increment idx; the edge with idx=N-1 finishes.
REQ-020 ADD SHALL be modulo 2^W, and any carry-out SHALL set the overflow flag sticky for that run; XOR, MAX and MIN SHALL leave it 0.
REQ-021 Finishing SHALL load result and ovf from the final acc and overflow flag, set valid=1, pulse done for exactly one cycle, and return to IDLE.
REQ-022 done SHALL be high in the cycle after edge k+N-1, so N=4 gives done 4 cycles after start is sampled.
REQ-023 busy SHALL be 1 from the cycle after edge k through the last RUN cycle, and 0 in the done cycle; back-to-back start in the done cycle SHALL be accepted.
REQ-024 valid SHALL clear at each accepted start and re-set at finish; result SHALL hold its old value until the finish edge.
REQ-025 In RUN, operand registers SHALL be frozen: a rising strobe SHALL NOT load and SHALL pulse load_err once per rejected edge, with the strobe history still updated.
REQ-026 A change of op in RUN SHALL have no effect on the run in progress.

Reset
REQ-027 rst=1 at a clock edge SHALL take effect regardless of state, including mid-RUN, which aborts the run with no done pulse.
REQ-028 Reset SHALL force: FSM=IDLE; all operand registers, acc, idx and strobe history to 0; result=0; ovf=0; busy=0; done=0; valid=0; load_err=0.

Structure
REQ-029 A shared package SHALL hold the op encodings (OP_ADD=0, OP_XOR=1, OP_MAX=2, OP_MIN=3) and the FSM state encoding.
REQ-030 The combine function SHALL be a combinational sub-module reduce_alu with inputs a, b and op, and outputs y and carry.
REQ-031 Operand storage SHALL be an N-entry W-bit register array.

Verification (W=4, N=4)
REQ-032 Load 3,5,7,9 on ch0..3, start with ADD -> done 4 cycles later, result=8, ovf=1, valid=1.
REQ-033 Same operands with XOR -> result=8, ovf=0; with MAX -> 9; with MIN -> 3; back-to-back starts in the done cycle are all accepted.
REQ-034 Hold load_stb[2]=1 for 5 cycles while data_in steps 1,2,3,4,5 -> reg2=1, no further loads.
REQ-035 Rising load_stb[1] in RUN with data_in=15 -> load_err pulses 1 cycle, reg1 unchanged, result matches the pre-load operands; start in RUN is ignored.
REQ-036 Assert rst on the 2nd RUN cycle -> next cycle busy=0, valid=0, result=0, no done; a fresh ADD with no loads gives result=0.
REQ-037 Build with N=1, W=8, load 200, ADD -> done in the cycle after the start edge, result=200, ovf=0.
